param_sp_memory: RTL and testbench
==================================

PARAM_SP_MEMORY -- requirements
Module: param_sp_memory

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8, range 8..128.
REQ-002 Parameter DEPTH, default 256, number of words; SHALL be in the range 2..4096 and need not be a power of two.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles; SHALL be 1 or 2.
REQ-004 Derived constant ADDR_W = $clog2(DEPTH); derived constant BE_W = DATA_W/8.
REQ-005 clk  input  1  single clock; all logic SHALL operate on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  word address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 req_be  input  BE_W  byte enables for writes; ignored on reads.
REQ-013 rsp_valid  output  1  read data valid; single-cycle pulse with no backpressure.
REQ-014 rsp_rdata  output  DATA_W  read data.
REQ-015 rsp_err  output  1  response error flag; qualified by rsp_valid.
REQ-016 init_done  output  1  memory clear complete.

Function
REQ-017 The FSM SHALL have states INIT and RUN; rst SHALL force INIT; INIT SHALL go to RUN after the last word is cleared; RUN SHALL be held until the next rst.
REQ-018 INIT SHALL write zero to addresses 0..DEPTH-1, one per cycle, taking exactly DEPTH cycles; init_done SHALL rise in the first RUN cycle.
REQ-019 req_ready SHALL be 1 in RUN and 0 in INIT; a request is accepted when req_valid && req_ready.
REQ-020 An accepted write SHALL update only the bytes whose req_be bit is 1; req_be = 0 SHALL leave memory unchanged; a write SHALL produce no response.
REQ-021 An accepted read SHALL assert rsp_valid exactly RD_LAT cycles after acceptance, with rsp_rdata holding the word addressed.
REQ-022 Back-to-back reads SHALL sustain one response per cycle, returned in order.
REQ-023 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-024 If req_addr >= DEPTH, a write SHALL be dropped, and a read SHALL return rsp_rdata = 0 with rsp_err = 1.
REQ-025 When rsp_valid = 0, rsp_rdata SHALL hold its last value and rsp_err SHALL be 0.

Reset
REQ-026 On rst, the outputs SHALL take these values on the next edge: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_done = 0, req_ready = 0.
REQ-027 rst asserted mid-read SHALL flush the read pipeline so that no rsp_valid is issued for that read.
REQ-028 rst asserted mid-INIT SHALL restart the clear sequence at address 0.

Configuration
REQ-029 With SPM_PARITY_EN defined, the block SHALL store one even-parity bit per byte, written with the byte and cleared in INIT; a read with any byte parity mismatch SHALL set rsp_err = 1 while still returning the stored data.
REQ-030 Without SPM_PARITY_EN, no parity storage SHALL exist, and rsp_err SHALL be driven only by REQ-024.

Structure
REQ-031 The shared package spm_pkg SHALL hold the state enum type (INIT, RUN) and the parameter-range check constants.
REQ-032 The storage array plus its optional parity bits SHALL live in one sub-module, spm_array; the FSM, handshake and read pipeline SHALL be in param_sp_memory.

Verification
REQ-033 Reset, DEPTH=256: pulse rst for 1 cycle -> req_ready = 0 for 256 cycles, then init_done = 1; a read of address 0x80 then returns 0x00000000.
REQ-034 Byte enables: write 0xAABBCCDD to address 5 with be = 4'b1111, then write 0x11223344 to address 5 with be = 4'b0101 -> a read of address 5 returns 0xAA22CC44.
REQ-035 Latency and throughput: RD_LAT=2, reads of addresses 1, 2, 3 in consecutive cycles -> rsp_valid is high in cycles +2, +3, +4 with the data in order.
REQ-036 Out of range: DEPTH=200, read of address 210 -> rsp_valid = 1, rsp_rdata = 0, rsp_err = 1; a write to address 210 leaves all memory unchanged.
REQ-037 Reset mid-read: rst asserted 1 cycle after a read is accepted with RD_LAT=2 -> no rsp_valid is seen and INIT restarts.
REQ-038 SPM_PARITY_EN defined: a write/read round trip gives rsp_err = 0; forcing one stored parity bit gives rsp_err = 1 with the data unchanged.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared state type and parameter limits for param_sp_memory.
// Optional per-byte parity is enabled by defining SPM_PARITY_EN.
package spm_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } spm_state_e;

    localparam int unsigned SPM_DATA_W_MIN = 8;
    localparam int unsigned SPM_DATA_W_MAX = 128;
    localparam int unsigned SPM_DEPTH_MIN  = 2;
    localparam int unsigned SPM_DEPTH_MAX  = 4096;
    localparam int unsigned SPM_RD_LAT_MIN = 1;
    localparam int unsigned SPM_RD_LAT_MAX = 2;

endpackage

// File: rtl/spm_array.sv
// Word storage with byte-enabled writes and combinational read.
// With SPM_PARITY_EN defined, one even-parity bit per byte is stored and checked.
module spm_array
    import spm_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 256,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_perr
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

`ifdef SPM_PARITY_EN
    logic [BE_W-1:0] r_par [0:DEPTH-1];
    logic [BE_W-1:0] w_par_calc;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_par[i_addr][b] <= ^i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Stored bit equals XOR of the byte, so a mismatch means the pair is no longer even.
    always_comb begin
        w_par_calc = '0;
        for (int unsigned b = 0; b < BE_W; b++) begin
            w_par_calc[b] = ^o_rdata[b*8 +: 8];
        end
    end

    assign o_perr = |(w_par_calc ^ r_par[i_addr]);
`else
    assign o_perr = 1'b0;
`endif

endmodule

// File: rtl/param_sp_memory.sv
// Single-port memory with power-up clear, byte enables and 1- or 2-cycle read latency.
// Define SPM_PARITY_EN to add per-byte parity checking on reads.
module param_sp_memory
    import spm_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 256,
    parameter  int unsigned RD_LAT = 1,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    if (DATA_W < SPM_DATA_W_MIN || DATA_W > SPM_DATA_W_MAX || (DATA_W % 8) != 0 ||
        DEPTH < SPM_DEPTH_MIN || DEPTH > SPM_DEPTH_MAX ||
        RD_LAT < SPM_RD_LAT_MIN || RD_LAT > SPM_RD_LAT_MAX) begin : g_param_check
        $error("param_sp_memory: parameter out of range");
    end

    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

    spm_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_init_addr;
    logic              w_init_last;
    logic              w_oor;
    logic              w_arr_we;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [DATA_W-1:0] w_arr_wdata;
    logic [BE_W-1:0]   w_arr_be;
    logic [DATA_W-1:0] w_arr_rdata;
    logic              w_arr_perr;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_err;
    logic              w_s_valid;
    logic [DATA_W-1:0] w_s_data;
    logic              w_s_err;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    assign w_init_last = (r_init_addr == LP_LAST);
    assign w_oor       = ({1'b0, req_addr} >= LP_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT;
            r_init_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT) begin
                r_init_addr <= w_init_last ? '0 : r_init_addr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        w_arr_we    = 1'b0;
        w_arr_addr  = req_addr;
        w_arr_wdata = req_wdata;
        w_arr_be    = req_be;
        case (r_state)
            INIT: begin
                w_arr_we    = 1'b1;
                w_arr_addr  = r_init_addr;
                w_arr_wdata = '0;
                w_arr_be    = '1;
                if (w_init_last) w_state_nxt = RUN;
            end
            RUN: begin
                req_ready = 1'b1;
                w_arr_we  = req_valid && req_we && !w_oor;
            end
            default: w_state_nxt = INIT;
        endcase
    end

    assign init_done = (r_state == RUN);

    spm_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk    (clk),
        .i_we   (w_arr_we),
        .i_addr (w_arr_addr),
        .i_wdata(w_arr_wdata),
        .i_be   (w_arr_be),
        .o_rdata(w_arr_rdata),
        .o_perr (w_arr_perr)
    );

    assign w_rd_acc  = req_valid && req_ready && !req_we;
    assign w_rd_data = w_oor ? '0 : w_arr_rdata;
    assign w_rd_err  = w_oor || w_arr_perr;

    if (RD_LAT == 2) begin : g_lat2
        logic              r_v1;
        logic [DATA_W-1:0] r_d1;
        logic              r_e1;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v1 <= 1'b0;
            end else begin
                r_v1 <= w_rd_acc;
            end
            if (w_rd_acc) begin
                r_d1 <= w_rd_data;
                r_e1 <= w_rd_err;
            end
        end

        assign w_s_valid = r_v1;
        assign w_s_data  = r_d1;
        assign w_s_err   = r_e1;
    end else begin : g_lat1
        assign w_s_valid = w_rd_acc;
        assign w_s_data  = w_rd_data;
        assign w_s_err   = w_rd_err;
    end

    // Read data only moves with a response, so it holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_s_valid;
            r_rsp_err   <= w_s_valid && w_s_err;
            if (w_s_valid) r_rsp_rdata <= w_s_data;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_param_sp_memory.sv
// Bench for param_sp_memory: instance A uses defaults, instance B uses DEPTH=200, RD_LAT=2.
// Read responses are scoreboarded with their expected arrival cycle.
module tb_param_sp_memory;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    logic        a_rst = 1'b0, a_req_valid = 1'b0, a_req_we = 1'b0;
    logic [7:0]  a_req_addr = '0;
    logic [31:0] a_req_wdata = '0;
    logic [3:0]  a_req_be = '0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_init_done;
    logic [31:0] a_rsp_rdata;

    logic        b_rst = 1'b0, b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [7:0]  b_req_addr = '0;
    logic [31:0] b_req_wdata = '0;
    logic [3:0]  b_req_be = '0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_init_done;
    logic [31:0] b_rsp_rdata;

    param_sp_memory dut_a (
        .clk(clk), .rst(a_rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .init_done(a_init_done)
    );

    param_sp_memory #(.DATA_W(32), .DEPTH(200), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(b_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .init_done(b_init_done)
    );

    logic        a_prev_rst = 1'b1, b_prev_rst = 1'b1;
    logic [31:0] a_last = '0, b_last = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (a_rsp_valid === 1'b1) begin
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected_rsp: got rdata=%h err=%b, expected no response", a_rsp_rdata, a_rsp_err);
                end else begin
                    ea = q_a.pop_front();
                    if (a_rsp_rdata !== ea.data || a_rsp_err !== ea.err || cyc != ea.due) begin
                        errors++;
                        $display("FAIL a_rsp: got data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                                 a_rsp_rdata, a_rsp_err, cyc, ea.data, ea.err, ea.due);
                    end
                end
            end else begin
                checks++;
                if (a_rsp_err !== 1'b0 || (!a_prev_rst && a_rsp_rdata !== a_last)) begin
                    errors++;
                    $display("FAIL a_idle_hold: got err=%b rdata=%h, expected err=0 rdata=%h", a_rsp_err, a_rsp_rdata, a_last);
                end
                if (q_a.size() != 0 && q_a[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL a_missing_rsp: got no rsp_valid by cyc=%0d, expected at cyc=%0d", cyc, q_a[0].due);
                    void'(q_a.pop_front());
                end
            end
        end
        a_last     = a_rsp_rdata;
        a_prev_rst = a_rst;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (b_rsp_valid === 1'b1) begin
                checks++;
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected_rsp: got rdata=%h err=%b, expected no response", b_rsp_rdata, b_rsp_err);
                end else begin
                    eb = q_b.pop_front();
                    if (b_rsp_rdata !== eb.data || b_rsp_err !== eb.err || cyc != eb.due) begin
                        errors++;
                        $display("FAIL b_rsp: got data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                                 b_rsp_rdata, b_rsp_err, cyc, eb.data, eb.err, eb.due);
                    end
                end
            end else begin
                checks++;
                if (b_rsp_err !== 1'b0 || (!b_prev_rst && b_rsp_rdata !== b_last)) begin
                    errors++;
                    $display("FAIL b_idle_hold: got err=%b rdata=%h, expected err=0 rdata=%h", b_rsp_err, b_rsp_rdata, b_last);
                end
                if (q_b.size() != 0 && q_b[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL b_missing_rsp: got no rsp_valid by cyc=%0d, expected at cyc=%0d", cyc, q_b[0].due);
                    void'(q_b.pop_front());
                end
            end
        end
        b_last     = b_rsp_rdata;
        b_prev_rst = b_rst;
    end

    // Drivers: called at posedge+1, request is accepted on the following edge.
    task automatic drv(input int d, input logic v, input logic we, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
        if (d == 0) begin
            a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_be = be;
        end else begin
            b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_wdata = wd; b_req_be = be;
        end
    endtask

    task automatic wr(input int d, input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] be);
        drv(d, 1'b1, 1'b1, addr, wd, be);
        @(posedge clk); #1;
        drv(d, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    endtask

    task automatic rd(input int d, input logic [7:0] addr, input logic [31:0] ed, input logic ee);
        exp_t e;
        e.data = ed;
        e.err  = ee;
        e.due  = cyc + ((d == 0) ? 1 : 2);
        if (d == 0) q_a.push_back(e); else q_b.push_back(e);
        drv(d, 1'b1, 1'b0, addr, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        drv(d, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    endtask

    task automatic drain;
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d responses outstanding, expected 0/0", q_a.size(), q_b.size());
        end
    endtask

    task automatic test_reset;
        int n;
        @(posedge clk); #1;
        a_rst = 1'b1; b_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0; b_rst = 1'b0;
        checks++;
        if ({a_rsp_valid, a_rsp_rdata, a_rsp_err, a_init_done, a_req_ready} !== 36'h0) begin
            errors++;
            $display("FAIL a_reset_outputs: got valid=%b rdata=%h err=%b done=%b ready=%b, expected all 0",
                     a_rsp_valid, a_rsp_rdata, a_rsp_err, a_init_done, a_req_ready);
        end
        checks++;
        if ({b_rsp_valid, b_rsp_rdata, b_rsp_err, b_init_done, b_req_ready} !== 36'h0) begin
            errors++;
            $display("FAIL b_reset_outputs: got valid=%b rdata=%h err=%b done=%b ready=%b, expected all 0",
                     b_rsp_valid, b_rsp_rdata, b_rsp_err, b_init_done, b_req_ready);
        end
        mon_en = 1'b1;
        // Reset again mid-clear: the full 256-cycle sequence must start over.
        repeat (100) @(posedge clk);
        #1 a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        n = 0;
        while (a_req_ready !== 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 256 || a_init_done !== 1'b1) begin
            errors++;
            $display("FAIL a_init_cycles: got %0d cycles done=%b, expected 256 cycles done=1", n, a_init_done);
        end
        checks++;
        if (b_init_done !== 1'b1 || b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b_init_done: got done=%b ready=%b, expected 1/1", b_init_done, b_req_ready);
        end
        rd(0, 8'h80, 32'h0000_0000, 1'b0);
        drain();
    endtask

    task automatic test_byte_enable;
        wr(0, 8'd5, 32'hAABB_CCDD, 4'b1111);
        wr(0, 8'd5, 32'h1122_3344, 4'b0101);
        rd(0, 8'd5, 32'hAA22_CC44, 1'b0);
        wr(0, 8'd5, 32'hFFFF_FFFF, 4'b0000);
        rd(0, 8'd5, 32'hAA22_CC44, 1'b0);
        wr(0, 8'd6, 32'h1234_5678, 4'b1000);
        rd(0, 8'd6, 32'h1200_0000, 1'b0);
        wr(0, 8'd255, 32'hCAFE_F00D, 4'b1111);
        rd(0, 8'd255, 32'hCAFE_F00D, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back;
        wr(1, 8'd1, 32'h0000_0101, 4'hF);
        wr(1, 8'd2, 32'h0000_0202, 4'hF);
        wr(1, 8'd3, 32'h0000_0303, 4'hF);
        rd(1, 8'd1, 32'h0000_0101, 1'b0);
        rd(1, 8'd2, 32'h0000_0202, 1'b0);
        rd(1, 8'd3, 32'h0000_0303, 1'b0);
        rd(0, 8'd5, 32'hAA22_CC44, 1'b0);
        rd(0, 8'd6, 32'h1200_0000, 1'b0);
        rd(0, 8'h80, 32'h0000_0000, 1'b0);
        drain();
    endtask

    task automatic test_out_of_range;
        wr(1, 8'd10, 32'h0A0A_0A0A, 4'hF);
        wr(1, 8'd82, 32'h5252_5252, 4'hF);
        wr(1, 8'd199, 32'hC7C7_C7C7, 4'hF);
        wr(1, 8'd210, 32'hDEAD_BEEF, 4'hF);
        rd(1, 8'd210, 32'h0000_0000, 1'b1);
        rd(1, 8'd200, 32'h0000_0000, 1'b1);
        rd(1, 8'd199, 32'hC7C7_C7C7, 1'b0);
        rd(1, 8'd10, 32'h0A0A_0A0A, 1'b0);
        rd(1, 8'd82, 32'h5252_5252, 1'b0);
        rd(1, 8'd1, 32'h0000_0101, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid_read;
        int n;
        drv(1, 1'b1, 1'b0, 8'd2, 32'h0, 4'h0);
        @(posedge clk); #1;
        drv(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        n = 0;
        while (b_req_ready !== 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 200 || b_init_done !== 1'b1) begin
            errors++;
            $display("FAIL b_reinit_cycles: got %0d cycles done=%b, expected 200 cycles done=1", n, b_init_done);
        end
        rd(1, 8'd2, 32'h0000_0000, 1'b0);
        rd(1, 8'd199, 32'h0000_0000, 1'b0);
        drain();
    endtask

`ifdef SPM_PARITY_EN
    task automatic test_parity;
        wr(0, 8'd7, 32'h0102_0304, 4'hF);
        rd(0, 8'd7, 32'h0102_0304, 1'b0);
        drain();
        dut_a.u_array.r_par[7] = dut_a.u_array.r_par[7] ^ 4'b0010;
        rd(0, 8'd7, 32'h0102_0304, 1'b1);
        drain();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: got no completion by 200000 ns, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_byte_enable();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_read();
`ifdef SPM_PARITY_EN
        test_parity();
`endif
        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
